// File: rtl/edge_write_sequencer.sv
// Write-back sequencer for the edge-detector tail: turns accepted pixels into
// SRAM writes in raster or serpentine order, offset by a per-frame base address.
module edge_write_sequencer #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              scan_mode_i,
  input  logic              out_sel_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic              hysteresis_result_i,
  input  logic [DATA_W-1:0] test_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW1 = ADDR_W + 1;

  localparam logic [XW-1:0]  X_MAX      = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_MAX      = YW'(IMG_H - 1);
  localparam logic [AW1-1:0] ROW_STRIDE = AW1'(IMG_W);

  generate
    if ((IMG_W < 2) || (IMG_H < 1)) begin : g_bad_dims
      $error("edge_write_sequencer: IMG_W must be >= 2 and IMG_H >= 1");
    end
    if ((longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("edge_write_sequencer: IMG_W*IMG_H does not fit in ADDR_W bits");
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mode_q, mode_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;

  logic              accept_s;
  logic              row_end_s;
  logic              last_s;
  logic [AW1-1:0]    lin_addr_s;
  // The carry out of the address sum is dropped: addresses wrap modulo 2^ADDR_W.
  logic              addr_carry_unused_s;

  assign pix_ready_o = (state_q == ST_RUN) && !abort_i;
  assign accept_s    = pix_valid_i && pix_ready_o;
  assign row_end_s   = (!mode_q || !dir_q) ? (x_q == X_MAX) : (x_q == {XW{1'b0}});
  assign last_s      = (y_q == Y_MAX) && row_end_s;
  assign lin_addr_s  = {1'b0, base_q} + (AW1'(y_q) * ROW_STRIDE) + AW1'(x_q);
  assign addr_carry_unused_s = lin_addr_s[ADDR_W];

  // Frame control, coordinate walk and write-port next state
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    base_d       = base_q;
    mode_d       = mode_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          x_d     = {XW{1'b0}};
          y_d     = {YW{1'b0}};
          dir_d   = 1'b0;
          base_d  = base_addr_i;
          mode_d  = scan_mode_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (accept_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = lin_addr_s[ADDR_W-1:0];
          wr_data_d = out_sel_i ? {DATA_W{hysteresis_result_i}} : test_data_i;
          if (last_s) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else if (!row_end_s) begin
            x_d = (mode_q && dir_q) ? (x_q - XW'(1)) : (x_q + XW'(1));
          end else begin
            // Serpentine turns around in place; raster returns to column 0.
            y_d = y_q + YW'(1);
            if (mode_q) begin
              dir_d = !dir_q;
            end else begin
              x_d = {XW{1'b0}};
            end
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      x_q          <= {XW{1'b0}};
      y_q          <= {YW{1'b0}};
      dir_q        <= 1'b0;
      base_q       <= {ADDR_W{1'b0}};
      mode_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= {ADDR_W{1'b0}};
      wr_data_q    <= {DATA_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_edge_write_sequencer.sv
// Scoreboard bench for edge_write_sequencer on a 4x3 image with 8-bit addresses.
module tb_edge_write_sequencer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_i = 1'b0, abort_i = 1'b0, scan_mode_i = 1'b0, out_sel_i = 1'b0;
  logic       pix_valid_i = 1'b0, hysteresis_result_i = 1'b0;
  logic [7:0] base_addr_i = 8'd0, test_data_i = 8'd0;
  logic       pix_ready_o, wr_en_o, busy_o, frame_done_o;
  logic [7:0] wr_addr_o, wr_data_o;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        done;
    logic [31:0] cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t e, o;
  int checks = 0;
  int errors = 0;
  int stray_done = 0;
  int m_k = 0;
  int m_base = 0;
  bit m_mode = 1'b0;
  bit m_active = 1'b0;
  logic [31:0] cyc = 32'd0;

  edge_write_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .scan_mode_i(scan_mode_i), .out_sel_i(out_sel_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .hysteresis_result_i(hysteresis_result_i), .test_data_i(test_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (n_rst && wr_en_o) obs_q.push_back(wr_t'({wr_addr_o, wr_data_o, frame_done_o, cyc}));
    if (n_rst && frame_done_o && !wr_en_o) stray_done <= stray_done + 1;
  end

  function automatic logic [7:0] exp_addr(input int k);
    int y, x;
    y = k / W;
    x = k % W;
    if (m_mode && (y % 2 == 1)) x = W - 1 - x;
    return 8'((m_base + y * W + x) % 256);
  endfunction

  task automatic start_frame(input int base, input bit mode);
    base_addr_i = 8'(base);
    scan_mode_i = mode;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    m_active = 1'b1;
    m_k = 0;
    m_base = base;
    m_mode = mode;
  endtask

  task automatic feed(input bit valid, input bit hr, input logic [7:0] td, input bit sel);
    bit acc;
    pix_valid_i = valid;
    hysteresis_result_i = hr;
    test_data_i = td;
    out_sel_i = sel;
    acc = valid && m_active && !abort_i;
    @(negedge clk);
    if (acc) begin
      exp_q.push_back(wr_t'({exp_addr(m_k), (sel ? {8{hr}} : td), (m_k == NPIX - 1), cyc}));
      m_k++;
      if (m_k == NPIX) m_active = 1'b0;
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    checks++;
    if ({pix_ready_o, wr_en_o, busy_o, frame_done_o, wr_addr_o, wr_data_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 00000", {pix_ready_o, wr_en_o, busy_o, frame_done_o, wr_addr_o, wr_data_o});
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pix_ready_o, wr_en_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got ready/wr_en/busy=%b, expected 000", {pix_ready_o, wr_en_o, busy_o});
    end
  endtask

  task automatic test_raster();
    start_frame(0, 1'b0);
    checks++;
    if ({busy_o, pix_ready_o} !== 2'b11) begin
      errors++;
      $display("FAIL raster_started: got busy/ready=%b, expected 11", {busy_o, pix_ready_o});
    end
    for (int k = 0; k < NPIX; k++) feed(1'b1, 1'b0, 8'(k * 7 + 3), 1'b0);
    checks++;
    if ({busy_o, pix_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL raster_done_state: got busy/ready=%b, expected 10", {busy_o, pix_ready_o});
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL raster_busy_fall: got busy=%b, expected 0", busy_o);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL raster_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL raster_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0) begin errors++; $display("FAIL raster_extra: got %0d extra writes %0d stray done, expected 0", obs_q.size(), stray_done); obs_q.delete(); end
  endtask

  task automatic test_serpentine();
    start_frame(16, 1'b1);
    for (int k = 0; k < NPIX; k++) feed(1'b1, (k % 2 == 0), 8'hA5, 1'b1);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL serp_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL serp_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0) begin errors++; $display("FAIL serp_extra: got %0d extra writes %0d stray done, expected 0", obs_q.size(), stray_done); obs_q.delete(); end
  endtask

  task automatic test_back_pressure();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    start_frame(40, 1'b0);
    for (int i = 0; i < 48 && m_active; i++) begin
      if (i == 4) begin
        start_i = 1'b1;
        base_addr_i = 8'd99;
        scan_mode_i = 1'b1;
      end
      feed(pat[i % 6], 1'b0, 8'(i + 100), 1'b0);
      start_i = 1'b0;
    end
    checks++;
    if (m_active) begin errors++; $display("FAIL bp_frame_len: got %0d accepts, expected %0d", m_k, NPIX); end
    @(negedge clk);
    scan_mode_i = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL bp_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL bp_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0) begin errors++; $display("FAIL bp_extra: got %0d extra writes %0d stray done, expected 0", obs_q.size(), stray_done); obs_q.delete(); end
  endtask

  task automatic test_wrap();
    start_frame(250, 1'b0);
    for (int k = 0; k < NPIX; k++) feed(1'b1, 1'b1, 8'h5A, (k % 3 == 0));
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0) begin errors++; $display("FAIL wrap_extra: got %0d extra writes %0d stray done, expected 0", obs_q.size(), stray_done); obs_q.delete(); end
  endtask

  task automatic test_abort();
    start_frame(100, 1'b0);
    for (int k = 0; k < 5; k++) feed(1'b1, 1'b0, 8'(k), 1'b0);
    abort_i = 1'b1;
    feed(1'b1, 1'b0, 8'hEE, 1'b0);
    abort_i = 1'b0;
    m_active = 1'b0;
    #1;
    checks++;
    if ({pix_ready_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got ready/busy=%b, expected 00", {pix_ready_o, busy_o});
    end
    @(negedge clk);
    start_frame(100, 1'b0);
    for (int k = 0; k < NPIX; k++) feed(1'b1, 1'b0, 8'(k + 20), 1'b0);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL abort_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL abort_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0) begin errors++; $display("FAIL abort_extra: got %0d extra writes %0d stray done, expected 0", obs_q.size(), stray_done); obs_q.delete(); end
  endtask

  task automatic test_reset_mid();
    start_frame(60, 1'b1);
    for (int k = 0; k < 3; k++) feed(1'b1, 1'b1, 8'h11, 1'b0);
    pix_valid_i = 1'b1;
    #2;
    n_rst = 1'b0;
    m_active = 1'b0;
    #1;
    checks++;
    if ({pix_ready_o, wr_en_o, busy_o, frame_done_o, wr_addr_o, wr_data_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got %h, expected 00000", {pix_ready_o, wr_en_o, busy_o, frame_done_o, wr_addr_o, wr_data_o});
    end
    @(negedge clk);
    checks++;
    if ({wr_en_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_held: got wr_en/busy=%b, expected 00", {wr_en_o, busy_o});
    end
    pix_valid_i = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rmid_write: got no write, expected addr=%0d", e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL rmid_write: got addr=%0d data=%h done=%b cyc=%0d, expected addr=%0d data=%h done=%b cyc=%0d", o.addr, o.data, o.done, o.cyc, e.addr, e.data, e.done, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || stray_done != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_extra: got %0d extra writes %0d stray done busy=%b, expected 0", obs_q.size(), stray_done, busy_o); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_serpentine();
    test_back_pressure();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_write_sequencer.md
# edge_write_sequencer

Parametrised write-back sequencer at the tail of the edge-detector pipeline. It accepts one pixel per handshake from the hysteresis stage and generates the SRAM write address for each pixel, in either raster or serpentine scan order, offset by a per-frame base address. Each SRAM write carries either the pass-through test data or the binarised hysteresis result. It replaces the fixed 512-wide, serpentine-only write controller, and adds frame start/done control and back-pressure.

## Interface
- IMG_W, default 512: pixels per row, ≥2.
- IMG_H, default 512: rows per frame, ≥1.
- ADDR_W, default 18: SRAM address width. Elaboration error if IMG_W*IMG_H > 2^ADDR_W.
- DATA_W, default 8: SRAM data width.
- clk, input, 1: clock, rising edge.
- n_rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a frame. Honoured only in IDLE.
- abort, input, 1: synchronous abandon of the current frame.
- base_addr, input, ADDR_W: frame base address, sampled on accepted start.
- scan_mode, input, 1: 0 = raster, 1 = serpentine. Sampled on accepted start.
- out_sel, input, 1: 0 = write test_data, 1 = write binarised hysteresis_result. Sampled per pixel.
- pix_valid, input, 1: pixel present.
- pix_ready, output, 1: sequencer accepts a pixel.
- hysteresis_result, input, 1: edge decision for the current pixel.
- test_data, input, DATA_W: raw pixel value for the current pixel.
- wr_en, output, 1: SRAM write strobe, one cycle per pixel.
- wr_addr, output, ADDR_W: SRAM write address.
- wr_data, output, DATA_W: SRAM write data.
- busy, output, 1: state ≠ IDLE.
- frame_done, output, 1: one-cycle pulse coincident with the last pixel's write.

## Operation
- States:
  - IDLE → RUN on start. On this transition: x=0, y=0, dir=0; base and mode latched.
  - RUN → DONE on acceptance of the last pixel.
  - DONE → IDLE unconditionally after one cycle.
  - abort in RUN → IDLE. abort has priority over acceptance in the same cycle. No frame_done on abort.
- pix_ready = 1 only in RUN and not abort. Acceptance = pix_valid & pix_ready.
- Address: wr_addr = (base + y*IMG_W + x) mod 2^ADDR_W. Compute in ADDR_W+1 bits, then truncate.
- Data: out_sel=1 gives wr_data = {DATA_W{hysteresis_result}}. out_sel=0 gives wr_data = test_data.
- Coordinate advance, on acceptance only:
  - Raster: x<IMG_W-1 → x+1. Otherwise x=0, y+1.
  - Serpentine, dir=0: x<IMG_W-1 → x+1. Otherwise y+1, dir=1, x unchanged.
  - Serpentine, dir=1: x>0 → x-1. Otherwise y+1, dir=0, x unchanged.
- Last pixel is y==IMG_H-1 and:
  - raster: x==IMG_W-1;
  - serpentine: x==IMG_W-1 if dir=0, x==0 if dir=1.
- x and y never exceed IMG_W-1 / IMG_H-1.
- start outside IDLE is ignored. start and abort together in IDLE: start wins.
- Parameter changes of base_addr or scan_mode mid-frame have no effect.

## Timing
- Reset values: pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, state IDLE.
- Reset mid-frame drops the frame immediately. No pending write is emitted.
- Latency: wr_en, wr_addr and wr_data are registered, one cycle after acceptance. wr_en=0 in cycles with no acceptance. wr_addr and wr_data hold their last value when wr_en=0.
- busy rises the cycle after start and falls after DONE (2 cycles after the last acceptance).
- frame_done is asserted in the DONE cycle, together with the last wr_en.
- pix_ready drops the cycle after the last acceptance.
- Throughput: one pixel per cycle with pix_valid held high. A frame takes IMG_W*IMG_H acceptances; the next start is accepted from IDLE, at the earliest 2 cycles after the last acceptance.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, ADDR_W=8, DATA_W=8.
- Raster frame, base=0, pix_valid held high → 12 consecutive wr_en. wr_addr 0..11. frame_done only with addr 11. busy falls the following cycle.
- Serpentine, base=16 → wr_addr 16,17,18,19,23,22,21,20,24,25,26,27. frame_done with 27.
- Data select:
  - out_sel=1, hysteresis_result alternating 1/0 → wr_data FF,00,FF,…
  - out_sel=0, test_data=0x5A → wr_data 0x5A.
- Back-pressure: pix_valid pattern 1,0,0,1,1,0 → wr_en only 1 cycle after each valid, addresses contiguous. start pulsed mid-frame → ignored.
- Wrap: base=250, raster → wr_addr 250..255,0..5. No errors.
- Abort and reset:
  - abort after 5 pixels → pix_ready=0 next cycle, no frame_done. A new start restarts at base.
  - n_rst low mid-frame → all outputs 0 asynchronously.
